// File: rtl/cpu_mem_pkg.sv
// Shared types for the MEM-stage data-memory interface.
//   DATA_W / ADDR_W : data and word-address widths seen by the pipeline.
//   dmem_state_t    : responder FSM states.
//   dmem_req_t      : a captured load/store request.
package cpu_mem_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous data RAM, no reset.
//   clk   : clock
//   en    : perform an access this edge
//   we    : 1 = write wdata to addr, 0 = read addr into rdata
//   addr  : word index
//   wdata : write data
//   rdata : read data, registered; changes only on a read access
module dmem_array #(
  parameter  int DEPTH  = 1024,
  parameter  int DATA_W = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the MEM-stage data-memory interface. Owns the data
// storage and services one load/store at a time after LATENCY wait cycles.
//
// Handshake: the requester asserts req_valid with req_we/req_addr/req_wdata.
// The request is accepted on any edge where the responder is in IDLE or RESP
// and req_valid=1. stall is high while an accepted access is in flight (and
// combinationally in the request cycle from IDLE); the requester keeps its
// inputs stable while stalled. rsp_valid pulses for one cycle when the
// access completes; rsp_rdata carries load data and holds between responses.
//
// Ports:
//   clk, rst (async, active-low)
//   req_valid, req_we, req_addr, req_wdata : request
//   stall, rsp_valid, rsp_rdata            : response
//   rsp_err                                : out-of-range access (DMEM_OOB_ERR_EN only)
//   dbg_state                              : current FSM state
//
// Build option DMEM_OOB_ERR_EN: addresses >= DEPTH are rejected (stores
// dropped, loads return zero, rsp_err raised). Without it, upper address
// bits are ignored and such addresses alias into the array.
module dmem_responder
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              rsp_valid,
`ifdef DMEM_OOB_ERR_EN
  output logic              rsp_err,
`endif
  output logic [DATA_W-1:0] rsp_rdata,
  output dmem_state_t       dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dmem_state_t       state, state_nx;
  dmem_req_t         cap;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] load_data;
  logic              accept;
  logic              access;
  logic              ram_en;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state; accept captures a request, access fires the RAM on the
  // WAIT-to-RESP transition.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    access   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nx = WAIT;
          accept   = 1'b1;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nx = RESP;
          access   = 1'b1;
        end
      end
      RESP: begin
        if (req_valid) begin
          state_nx = WAIT;
          accept   = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Captured request, wait counter and held load data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap     <= '0;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        cap <= '{we: req_we, addr: req_addr, wdata: req_wdata};
        cnt <= CW'(LATENCY - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (state == RESP && !cap.we) begin
        rdata_q <= load_data;
      end
    end
  end

`ifdef DMEM_OOB_ERR_EN
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  logic oob;
  assign oob       = {1'b0, cap.addr} >= DEPTH_L;
  assign ram_en    = access & ~oob;
  assign load_data = oob ? '0 : ram_rdata;
  assign rsp_err   = rsp_valid & oob;
`else
  // Upper address bits deliberately dropped: out-of-range addresses alias.
  logic unused_addr_hi;
  assign unused_addr_hi = ^cap.addr;
  assign ram_en         = access;
  assign load_data      = ram_rdata;
`endif

  dmem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (cap.we),
    .addr  (cap.addr[AW-1:0]),
    .wdata (cap.wdata),
    .rdata (ram_rdata)
  );

  // The RAM result lands in the RESP cycle, so the load data is forwarded
  // straight through then and held in rdata_q afterwards.
  assign rsp_rdata = (state == RESP && !cap.we) ? load_data : rdata_q;
  assign rsp_valid = (state == RESP);
  // Gated by rst so a mid-access reset releases the pipeline immediately,
  // even if req_valid is still asserted.
  assign stall     = rst & ((state == WAIT) | ((state == IDLE) & req_valid));
  assign dbg_state = state;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import cpu_mem_pkg::*;

  localparam int LAT = 2;
`ifdef DMEM_OOB_ERR_EN
  localparam bit OOB = 1'b1;
`else
  localparam bit OOB = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT0: DEPTH=1024, LATENCY=2 (table-driven)
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        stall, rsp_valid;
  logic [15:0] rsp_rdata;
  dmem_state_t dbg_state;
`ifdef DMEM_OOB_ERR_EN
  logic        rsp_err;
`endif

  // DUT1: DEPTH=16, LATENCY=1 (scoreboard)
  logic        rst1 = 1'b0;
  logic        v1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr1 = '0, wd1 = '0;
  logic        stall1, valid1;
  logic [15:0] rdata1;
  dmem_state_t dbg1;
`ifdef DMEM_OOB_ERR_EN
  logic        err1;
`endif

  dmem_responder #(.DEPTH(1024), .LATENCY(LAT)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .stall     (stall),
    .rsp_valid (rsp_valid),
`ifdef DMEM_OOB_ERR_EN
    .rsp_err   (rsp_err),
`endif
    .rsp_rdata (rsp_rdata),
    .dbg_state (dbg_state)
  );

  dmem_responder #(.DEPTH(16), .LATENCY(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst1),
    .req_valid (v1),
    .req_we    (we1),
    .req_addr  (addr1),
    .req_wdata (wd1),
    .stall     (stall1),
    .rsp_valid (valid1),
`ifdef DMEM_OOB_ERR_EN
    .rsp_err   (err1),
`endif
    .rsp_rdata (rdata1),
    .dbg_state (dbg1)
  );

  // ---------------- vectors / scoreboard ----------------
  typedef struct {
    logic        rst, v, we;
    logic [15:0] addr, wd;
    logic        es, ev;
    logic [15:0] erd;
    logic        eerr;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] exp_q[$];
  logic [15:0] mdl[16];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic void row(input logic r, input logic v, input logic we,
                              input logic [15:0] a, input logic [15:0] wd,
                              input logic es, input logic ev,
                              input logic [15:0] erd, input logic eerr);
    vec_t t;
    t.rst = r; t.v = v; t.we = we; t.addr = a; t.wd = wd;
    t.es = es; t.ev = ev; t.erd = erd; t.eerr = eerr;
    vecs.push_back(t);
  endfunction

  function automatic void idle_row(input logic [15:0] rd);
    row(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, rd, 1'b0);
  endfunction

  // One isolated transaction from IDLE: request + LAT wait cycles, then RESP.
  function automatic void add_txn(input logic we, input logic [15:0] a, input logic [15:0] wd,
                                  input logic [15:0] rd_prev, input logic [15:0] rd_new,
                                  input logic err);
    for (int i = 0; i <= LAT; i++) row(1'b1, 1'b1, we, a, wd, 1'b1, 1'b0, rd_prev, 1'b0);
    row(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, rd_new, err);
  endfunction

  // Driver for DUT1: issue one request, measure latency, check response.
  task automatic txn1(input logic we, input logic [15:0] a, input logic [15:0] wd);
    int          cyc;
    logic [15:0] exp;
    @(posedge clk); #1;
    v1 = 1'b1; we1 = we; addr1 = a; wd1 = wd;
    cyc = 0;
    @(negedge clk);
    while (!valid1 && cyc < 8) begin
      chk("l1_stall", 16'(stall1), 16'h1);
      @(posedge clk); #1;
      v1 = 1'b0;
      cyc++;
      @(negedge clk);
    end
    chk("l1_rsp_seen", 16'(valid1), 16'h1);
    chk("l1_latency", 16'(cyc), 16'd2);
    chk("l1_rsp_stall", 16'(stall1), 16'h0);
    if (!we) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL l1_expq_empty: got empty want entry");
      end else begin
        exp = exp_q.pop_front();
        chk("l1_rdata", rdata1, exp);
      end
    end
    @(posedge clk); #1;
    v1 = 1'b0;
  endtask

  // ---------------- main test ----------------
  initial begin
    logic [15:0] rd0, rd1, rd2, d;
    logic        w;
    logic [15:0] a;

    // Reset held 3 cycles, one with req_valid high: stall must stay low.
    row(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    row(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    row(1'b0, 1'b1, 1'b1, 16'h5, 16'hBEEF, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 10; i++) idle_row(16'h0);
    // Store 5=BEEF: stall cycles 0..2, rsp_valid cycle 3
    add_txn(1'b1, 16'h0005, 16'hBEEF, 16'h0, 16'h0, 1'b0);
    // Store 6=CAFE; load 5 presented in its RESP cycle
    for (int i = 0; i <= LAT; i++) row(1'b1, 1'b1, 1'b1, 16'h6, 16'hCAFE, 1'b1, 1'b0, 16'h0, 1'b0);
    row(1'b1, 1'b1, 1'b0, 16'h5, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0);
    // Load 5 in flight; load 6 presented back-to-back in its RESP cycle
    for (int i = 0; i < LAT; i++) row(1'b1, 1'b1, 1'b0, 16'h5, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    row(1'b1, 1'b1, 1'b0, 16'h6, 16'h0, 1'b0, 1'b1, 16'hBEEF, 1'b0);
    for (int i = 0; i < LAT; i++) row(1'b1, 1'b1, 1'b0, 16'h6, 16'h0, 1'b1, 1'b0, 16'hBEEF, 1'b0);
    row(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'hCAFE, 1'b0);
    idle_row(16'hCAFE);
    // Prior contents of 0x10, then an interrupted store of 1234
    add_txn(1'b1, 16'h0010, 16'hAAAA, 16'hCAFE, 16'hCAFE, 1'b0);
    row(1'b1, 1'b1, 1'b1, 16'h10, 16'h1234, 1'b1, 1'b0, 16'hCAFE, 1'b0);
    row(1'b1, 1'b1, 1'b1, 16'h10, 16'h1234, 1'b1, 1'b0, 16'hCAFE, 1'b0);
    row(1'b0, 1'b1, 1'b1, 16'h10, 16'h1234, 1'b0, 1'b0, 16'h0, 1'b0);
    idle_row(16'h0);
    idle_row(16'h0);
    add_txn(1'b0, 16'h0010, 16'h0, 16'h0, 16'hAAAA, 1'b0);
    // Out-of-range / aliasing behaviour
    add_txn(1'b1, 16'h0000, 16'h1111, 16'hAAAA, 16'hAAAA, 1'b0);
    add_txn(1'b1, 16'h0400, 16'h5555, 16'hAAAA, 16'hAAAA, OOB);
    rd0 = OOB ? 16'h1111 : 16'h5555;
    add_txn(1'b0, 16'h0000, 16'h0, 16'hAAAA, rd0, 1'b0);
    rd1 = OOB ? 16'h0000 : 16'h5555;
    add_txn(1'b0, 16'h0400, 16'h0, rd0, rd1, OOB);
    rd2 = OOB ? 16'h0000 : 16'hCAFE;
    add_txn(1'b0, 16'h8006, 16'h0, rd1, rd2, OOB);
    idle_row(rd2);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      rst       = vecs[i].rst;
      req_valid = vecs[i].v;
      req_we    = vecs[i].we;
      req_addr  = vecs[i].addr;
      req_wdata = vecs[i].wd;
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), 16'(stall), 16'(vecs[i].es));
      chk($sformatf("v%0d_rsp_valid", i), 16'(rsp_valid), 16'(vecs[i].ev));
      chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vecs[i].erd);
`ifdef DMEM_OOB_ERR_EN
      chk($sformatf("v%0d_rsp_err", i), 16'(rsp_err), 16'(vecs[i].eerr));
`endif
      if (i == 2) chk("rst_state", 16'(dbg_state), 16'(IDLE));
    end

    // LATENCY=1 instance: reset values, directed load, then random mix
    @(negedge clk);
    chk("l1_rst_stall", 16'(stall1), 16'h0);
    chk("l1_rst_valid", 16'(valid1), 16'h0);
    chk("l1_rst_rdata", rdata1, 16'h0);
    @(posedge clk); #1;
    rst1 = 1'b1;
    txn1(1'b1, 16'h3, 16'h7777);
    exp_q.push_back(16'h7777);
    txn1(1'b0, 16'h3, 16'h0);
    for (int i = 0; i < 16; i++) begin
      d = 16'($urandom_range(0, 65535));
      mdl[i] = d;
      txn1(1'b1, 16'(i), d);
    end
    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 16'($urandom_range(0, 15));
      d = 16'($urandom_range(0, 65535));
      if (w) begin
        mdl[a[3:0]] = d;
      end else begin
        exp_q.push_back(mdl[a[3:0]]);
      end
      txn1(w, a, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the MEM-stage data-memory interface.
- The pipeline's MEM slice issues a load/store request. This block owns the data storage and services the request after a programmable latency.
- It holds `stall` high until the access completes, then returns read data with a one-cycle valid pulse.
- It replaces the zero-latency memory so that multi-cycle memory timing can be exercised in the pipeline.

Parameters:
- DEPTH, 1024, number of 16-bit data words; power of two, at least 2.
- LATENCY, 2, wait cycles between request acceptance and response; at least 1.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- req_valid  input  1  MEM stage presents an access this cycle.
- req_we  input  1  1 = store, 0 = load; sampled with req_valid.
- req_addr  input  16  word address; low AW = $clog2(DEPTH) bits index storage.
- req_wdata  input  16  store data.
- stall  output  1  freeze the pipeline; access in progress.
- rsp_valid  output  1  one-cycle pulse: access complete.
- rsp_rdata  output  16  load data; held between responses.

Behaviour:
- One clock; reset is asynchronous and active-low.
- States: IDLE, WAIT, RESP.
- Reset (rst=0), applied asynchronously:
  - state=IDLE, counter=0, rsp_valid=0, rsp_rdata=16'h0000.
  - Captured request is cleared.
  - Storage contents are NOT reset.
- IDLE, req_valid=1:
  - Capture we, addr and wdata.
  - counter <= LATENCY-1; go to WAIT.
- IDLE, req_valid=0: remain in IDLE.
- WAIT:
  - counter decrements each cycle.
  - When counter==0, perform the access:
    - store: mem[addr] <= wdata.
    - load: rsp_rdata <= mem[addr].
  - Then go to RESP.
- RESP:
  - rsp_valid=1 for exactly this cycle; stall=0.
  - req_valid=1 in this cycle: capture it and go to WAIT (back-to-back, no idle bubble).
  - Otherwise go to IDLE.
- stall is combinational: (state==WAIT) | (state==IDLE & req_valid). It is 0 in RESP and 0 while rst=0.
- Timing: request presented in cycle 0 gives stall high in cycles 0..LATENCY and rsp_valid high in cycle LATENCY+1.
- Inputs are ignored while in WAIT; the requester must hold them stable, but the captured copy is used.
- Store responses also pulse rsp_valid; rsp_rdata is unchanged on a store.
- Read-after-write to the same address returns the new data.
- Address above DEPTH-1 wraps by truncation (upper bits ignored).
- Reset mid-access: the access is aborted, a pending store is dropped, no rsp_valid is issued, and stall deasserts immediately.

Optional Feature:
- Macro: DMEM_OOB_ERR_EN.
- Defined:
  - Adds port `rsp_err  output  1`, reset 0, valid only with rsp_valid.
  - For an access with req_addr >= DEPTH: the store is discarded; a load returns 16'h0000; rsp_err=1 on the response cycle.
  - Latency is unchanged.
- Undefined:
  - No rsp_err port.
  - Out-of-range addresses alias by truncation, as above.

Decomposition:
- Package cpu_mem_pkg:
  - DATA_W=16 and ADDR_W=16 constants.
  - dmem_state_t enum {IDLE, WAIT, RESP}.
  - Request struct: we, addr, wdata.
- Sub-module dmem_array:
  - Single-port synchronous RAM with DEPTH and DATA_W parameters.
  - Ports: clk, en, we, addr, wdata, rdata.
  - No reset.
  - The FSM drives en on the WAIT-to-RESP transition.

Test Plan:
- Reset, then idle: rst low for 3 cycles then high, req_valid=0 → stall=0, rsp_valid=0, rsp_rdata=0000 for 10 cycles.
- Store then load, LATENCY=2:
  - Store addr 0x0005, data 0xBEEF at cycle 0 → stall high in cycles 0–2; rsp_valid in cycle 3 only.
  - Load 0x0005 at cycle 4 → rsp_valid in cycle 7 with rsp_rdata=BEEF; stall low in cycle 7.
- Back-to-back: a new load to 0x0006 presented in the RESP cycle → accepted with no IDLE cycle; next rsp_valid exactly 3 cycles later.
- Mid-access reset: store 0x0010=0x1234, rst low in the WAIT cycle → stall drops immediately, no rsp_valid. Afterwards, load 0x0010 returns the prior contents, not 1234.
- LATENCY=1 sweep: a load at cycle 0 → stall in cycles 0–1, rsp_valid in cycle 2.
- With DMEM_OOB_ERR_EN, DEPTH=1024:
  - Store 0x0400=0x5555 → rsp_err=1.
  - Load 0x0000 → rsp_err=0, original data.
  - Load 0x0400 → rsp_rdata=0000, rsp_err=1.
  - Without the macro, the load of 0x0400 aliases to 0x0000 and returns 5555.
